counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Sequencer for the address Counter block: accepts a transfer command (start + length) and drives the Counter's en/done_i inputs.
- Presents each count value downstream as an address beat under a valid/ready handshake.
- Clears the Counter when the transfer finishes or aborts, then signals completion.
- Sits between the command/control logic and the memory-side consumer; the Counter instance lives alongside it in the same parent.

Parameters:
- CNT_WIDTH, 7, width of Counter value, addresses and length (max 127 beats per transfer).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  command strobe; sampled only in IDLE.
- len_i  input  CNT_WIDTH  beat count for the command; captured with start_i.
- abort_i  input  1  terminate the current transfer early.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle completion pulse.
- cnt_en_o  output  1  to Counter en.
- cnt_clr_o  output  1  to Counter done_i.
- cnt_i  input  CNT_WIDTH  from Counter cnt_o.
- cnt_valid_i  input  1  from Counter valid_o.
- addr_valid_o  output  1  address beat valid.
- addr_o  output  CNT_WIDTH  address beat; combinationally equal to cnt_i.
- addr_ready_i  input  1  consumer accepts the beat.
- err_o  output  1  sticky sequencing error (optional feature only).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, beats_left 0. All outputs 0: busy_o, done_o, cnt_en_o, cnt_clr_o, addr_valid_o, err_o.
- Reset mid-transfer returns to IDLE immediately. The Counter shares rst_n and also resets to 0.
- FSM states: IDLE, RUN, CLEAR, DONE. State register is updated on the clock edge; outputs are decoded from state.
- IDLE:
  - start_i=1 and len_i!=0: load beats_left=len_i, go to RUN.
  - start_i=1 and len_i=0: go to CLEAR (no beats issued).
  - start_i=0: stay in IDLE.
- RUN:
  - addr_valid_o=1, addr_o=cnt_i.
  - Beat = addr_valid_o & addr_ready_i. cnt_en_o = beat, so the Counter shows the next address the following cycle; back-to-back beats have no bubble.
  - On each beat, beats_left decrements.
  - Beat with beats_left==1: go to CLEAR.
- Handshake rules: addr_valid_o stays high and addr_o stays stable while addr_ready_i=0. The only exception is abort.
- abort_i in RUN: go to CLEAR next cycle. A beat in the same cycle still counts (cnt_en_o asserts) but produces no further beats. abort_i is ignored in all other states.
- CLEAR: cnt_clr_o=1 for exactly one cycle, then go to DONE. Counter returns to 0 with valid_o=0.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Invariant: cnt_en_o and cnt_clr_o are never high in the same cycle. This matters because the Counter gives en priority over done_i.
- busy_o=1 in RUN, CLEAR and DONE. start_i in any state other than IDLE is ignored (no queuing).
- Timing, start in cycle T with ready held high and len=N:
  - beats in cycles T+1..T+N;
  - cnt_clr_o in T+N+1;
  - done_o in T+N+2;
  - IDLE in T+N+3.
- len_i arithmetic: unsigned. The maximum of 2^CNT_WIDTH-1 beats keeps cnt_i from wrapping within a transfer.

Optional Feature:
- Macro: COUNTER_SEQ_CHECK_EN.
- Defined: an internal expected index resets to 0 at transfer start and increments on each beat. err_o sets (sticky until rst_n) when either:
  - in RUN, cnt_i differs from the expected index; or
  - in DONE, cnt_i!=0 or cnt_valid_i!=0.
- Not defined: err_o tied to 0, no checker logic; cnt_valid_i is unused.

Test Plan:
- Basic run, addr_ready_i=1, start_i with len_i=3 at cycle T:
  - addr_o 0,1,2 in T+1..T+3;
  - cnt_clr_o=1 in T+4; done_o=1 in T+5;
  - busy_o=0 and cnt_i=0 in T+6.
- Backpressure, len_i=2, addr_ready_i=0 for 3 cycles after the first valid:
  - addr_o holds 0 and cnt_en_o=0 during the stall;
  - after ready rises, beats 0 then 1 are accepted; done_o fires 2 cycles after the last beat.
- Zero length, start_i with len_i=0:
  - no addr_valid_o;
  - cnt_clr_o at T+1, done_o at T+2.
- Abort after 2 accepted beats of len_i=10:
  - addr_valid_o drops the next cycle;
  - cnt_clr_o pulses once, then done_o; Counter reads 0.
- start_i pulsed in RUN, and reset asserted mid-RUN:
  - start_i in RUN is ignored, and the original transfer completes with the original length;
  - rst_n low forces all outputs to 0 immediately; next start runs from address 0.
- With COUNTER_SEQ_CHECK_EN: force cnt_i to 5 while the expected index is 1 in RUN → err_o=1 and stays high until rst_n.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the address Counter: runs a start/length command, hands each count out as an address beat,
// then clears the Counter and pulses done. Optional sequencing checker enabled by COUNTER_SEQ_CHECK_EN.
module counter_seq_ctrl #(
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cnt_en_o,
  output logic                 cnt_clr_o,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 cnt_valid_i,
  output logic                 addr_valid_o,
  output logic [CNT_WIDTH-1:0] addr_o,
  input  logic                 addr_ready_i,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] beatsLeft_q, beatsLeft_d;
  logic                 beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beatsLeft_q <= '0;
    end else begin
      state_q     <= state_d;
      beatsLeft_q <= beatsLeft_d;
    end
  end

  // The Counter gives en priority over done_i, so en is only ever raised in RUN and clr only in CLEAR.
  always_comb begin
    state_d      = state_q;
    beatsLeft_d  = beatsLeft_q;
    busy_o       = (state_q != IDLE);
    done_o       = 1'b0;
    cnt_en_o     = 1'b0;
    cnt_clr_o    = 1'b0;
    addr_valid_o = 1'b0;
    beat         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            beatsLeft_d = len_i;
            state_d     = RUN;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      RUN: begin
        addr_valid_o = 1'b1;
        beat         = addr_ready_i;
        cnt_en_o     = beat;
        if (beat) begin
          beatsLeft_d = beatsLeft_q - CNT_WIDTH'(1);
        end
        if (abort_i || (beat && (beatsLeft_q == CNT_WIDTH'(1)))) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr_o = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_o = cnt_i;

`ifdef COUNTER_SEQ_CHECK_EN
  logic [CNT_WIDTH-1:0] expIdx_q;
  logic                 err_q;

  // Tracks the address the Counter should be showing; any divergence latches the error until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expIdx_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start_i) begin
        expIdx_q <= '0;
      end else if (beat) begin
        expIdx_q <= expIdx_q + CNT_WIDTH'(1);
      end
      if (((state_q == RUN) && (cnt_i != expIdx_q)) ||
          ((state_q == DONE) && ((cnt_i != '0) || cnt_valid_i))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  logic unusedCntValid;
  assign unusedCntValid = cnt_valid_i;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural Counter model feeding cnt_i/cnt_valid_i.
module tb_counter_seq_ctrl;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, abort_i, addr_ready_i;
  logic [W-1:0] len_i;
  logic         busy_o, done_o, cnt_en_o, cnt_clr_o, addr_valid_o, err_o;
  logic [W-1:0] addr_o, cnt_i;
  logic         cnt_valid_i;

  logic [W-1:0] cntModel;
  logic         cntValidModel;
  logic         forceCnt = 1'b0;
  logic [W-1:0] forceVal = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .cnt_en_o(cnt_en_o), .cnt_clr_o(cnt_clr_o),
    .cnt_i(cnt_i), .cnt_valid_i(cnt_valid_i), .addr_valid_o(addr_valid_o),
    .addr_o(addr_o), .addr_ready_i(addr_ready_i), .err_o(err_o)
  );

  // Counter model: en has priority over done_i, shares rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntModel      <= '0;
      cntValidModel <= 1'b0;
    end else if (cnt_en_o) begin
      cntModel      <= cntModel + W'(1);
      cntValidModel <= 1'b1;
    end else if (cnt_clr_o) begin
      cntModel      <= '0;
      cntValidModel <= 1'b0;
    end
  end

  assign cnt_i       = forceCnt ? forceVal : cntModel;
  assign cnt_valid_i = cntValidModel;

  typedef struct {
    logic         start;
    logic [W-1:0] len;
    logic         abort;
    logic         ready;
    logic [5:0]   expFlags;
    logic [W-1:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic s, input int l, input logic a, input logic r,
                        input logic b, input logic d, input logic e, input logic c,
                        input logic v, input int addr);
    vec_t t;
    t.start    = s;
    t.len      = W'(l);
    t.abort    = a;
    t.ready    = r;
    t.expFlags = {b, d, e, c, v, 1'b0};
    t.expAddr  = W'(addr);
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input logic s, input logic [W-1:0] l, input logic a, input logic r);
    @(posedge clk);
    #1;
    start_i      = s;
    len_i        = l;
    abort_i      = a;
    addr_ready_i = r;
  endtask

  // Flags are {busy, done, en, clr, valid, err}.
  task automatic checkOutput(input string name, input logic [5:0] expF, input logic [W-1:0] expA);
    logic [5:0] act;
    act = {busy_o, done_o, cnt_en_o, cnt_clr_o, addr_valid_o, err_o};
    checks++;
    if (act !== expF || addr_o !== expA) begin
      errors++;
      $display("[TB] FAIL %s flags=%b addr=%0d expected flags=%b addr=%0d", name, act, addr_o, expF, expA);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    int addrErrs;
    bit sawClr;

    rst_n = 1'b0; start_i = 1'b0; len_i = '0; abort_i = 1'b0; addr_ready_i = 1'b0;
    #3;
    checkOutput("reset", 6'b000000, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic run len=3
    addVec(1,3,0,1, 0,0,0,0,0,0);
    addVec(0,0,0,1, 1,0,1,0,1,0);
    addVec(0,0,0,1, 1,0,1,0,1,1);
    addVec(0,0,0,1, 1,0,1,0,1,2);
    addVec(0,0,0,1, 1,0,0,1,0,3);
    addVec(0,0,0,1, 1,1,0,0,0,0);
    addVec(0,0,0,1, 0,0,0,0,0,0);
    // backpressure len=2, three stall cycles
    addVec(1,2,0,0, 0,0,0,0,0,0);
    addVec(0,0,0,0, 1,0,0,0,1,0);
    addVec(0,0,0,0, 1,0,0,0,1,0);
    addVec(0,0,0,0, 1,0,0,0,1,0);
    addVec(0,0,0,1, 1,0,1,0,1,0);
    addVec(0,0,0,1, 1,0,1,0,1,1);
    addVec(0,0,0,0, 1,0,0,1,0,2);
    addVec(0,0,0,0, 1,1,0,0,0,0);
    addVec(0,0,0,0, 0,0,0,0,0,0);
    // zero length
    addVec(1,0,0,1, 0,0,0,0,0,0);
    addVec(0,0,0,1, 1,0,0,1,0,0);
    addVec(0,0,0,1, 1,1,0,0,0,0);
    addVec(0,0,0,1, 0,0,0,0,0,0);
    // abort after two beats of len=10
    addVec(1,10,0,1, 0,0,0,0,0,0);
    addVec(0,0,0,1, 1,0,1,0,1,0);
    addVec(0,0,0,1, 1,0,1,0,1,1);
    addVec(0,0,1,0, 1,0,0,0,1,2);
    addVec(0,0,0,1, 1,0,0,1,0,2);
    addVec(0,0,0,1, 1,1,0,0,0,0);
    addVec(0,0,0,1, 0,0,0,0,0,0);
    // abort coinciding with a beat; abort ignored outside RUN
    addVec(1,5,0,1, 0,0,0,0,0,0);
    addVec(0,0,1,1, 1,0,1,0,1,0);
    addVec(0,0,1,1, 1,0,0,1,0,1);
    addVec(0,0,1,1, 1,1,0,0,0,0);
    addVec(0,0,1,1, 0,0,0,0,0,0);
    // start ignored in RUN, CLEAR and DONE
    addVec(1,2,0,1, 0,0,0,0,0,0);
    addVec(1,7,0,0, 1,0,0,0,1,0);
    addVec(1,7,0,1, 1,0,1,0,1,0);
    addVec(0,0,0,1, 1,0,1,0,1,1);
    addVec(1,3,0,1, 1,0,0,1,0,2);
    addVec(1,3,0,1, 1,1,0,0,0,0);
    addVec(0,0,0,1, 0,0,0,0,0,0);
    // single beat
    addVec(1,1,0,1, 0,0,0,0,0,0);
    addVec(0,0,0,1, 1,0,1,0,1,0);
    addVec(0,0,0,1, 1,0,0,1,0,1);
    addVec(0,0,0,1, 1,1,0,0,0,0);
    addVec(0,0,0,1, 0,0,0,0,0,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].len, vecs[i].abort, vecs[i].ready);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].expFlags, vecs[i].expAddr);
    end

    // reset asserted mid-RUN, then a fresh transfer starts from address 0
    applyStimulus(1, W'(5), 0, 1);
    @(negedge clk);
    checkOutput("rstStartIdle", 6'b000000, W'(0));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("rstRun0", 6'b101010, W'(0));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("rstRun1", 6'b101010, W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidRun", 6'b000000, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, W'(2), 0, 1);
    @(negedge clk);
    checkOutput("postRstIdle", 6'b000000, W'(0));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("postRstBeat0", 6'b101010, W'(0));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("postRstBeat1", 6'b101010, W'(1));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("postRstClr", 6'b100100, W'(2));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("postRstDone", 6'b110000, W'(0));

    // maximum length transfer: 127 beats, addresses 0..126 without wrap
    applyStimulus(1, W'(127), 0, 1);
    @(negedge clk);
    checkOutput("maxStart", 6'b000000, W'(0));
    beats = 0; addrErrs = 0; sawClr = 1'b0;
    for (int c = 0; c < 200 && !sawClr; c++) begin
      applyStimulus(0, '0, 0, 1);
      @(negedge clk);
      if (cnt_clr_o) sawClr = 1'b1;
      else if (addr_valid_o && cnt_en_o) begin
        if (addr_o !== W'(beats)) addrErrs++;
        beats++;
      end
    end
    checks++;
    if (!sawClr || beats != 127 || addrErrs != 0) begin
      errors++;
      $display("[TB] FAIL maxLen beats=%0d addrErrs=%0d clr=%0b expected beats=127 addrErrs=0 clr=1", beats, addrErrs, sawClr);
    end
    checkOutput("maxClrAddr", 6'b100100, W'(127));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("maxDone", 6'b110000, W'(0));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("maxIdle", 6'b000000, W'(0));

`ifdef COUNTER_SEQ_CHECK_EN
    // corrupted Counter value while expected index is 1 latches err_o until reset
    applyStimulus(1, W'(4), 0, 1);
    @(negedge clk);
    checkOutput("chkIdle", 6'b000000, W'(0));
    applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("chkBeat0", 6'b101010, W'(0));
    applyStimulus(0, '0, 0, 1);
    forceVal = W'(5);
    forceCnt = 1'b1;
    @(negedge clk);
    checkOutput("chkForced", 6'b101010, W'(5));
    applyStimulus(0, '0, 0, 1);
    forceCnt = 1'b0;
    @(negedge clk);
    checkOutput("chkErrSet", 6'b101011, W'(2));
    for (int c = 0; c < 4; c++) applyStimulus(0, '0, 0, 1);
    @(negedge clk);
    checkOutput("chkErrSticky", 6'b000001, W'(0));
    rst_n = 1'b0;
    #1;
    checkOutput("chkErrReset", 6'b000000, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
